// File: rtl/mult_share_arb.sv
// Purpose : round-robin arbiter sharing one 6x6 Wallace-tree multiplier among N_REQ requesters.
// Latency : ack in cycle N -> rsp_valid with the product from cycle N+2 (no stall in N+1).
// Backpr. : rsp_valid & ~rsp_ready freezes both stages and forces ack to zero.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req/x_in/y_in     per-requester request with 6-bit operand slices [6i+5:6i]
//   ack               one-hot capture pulse, sample at the rising edge
//   rsp_valid/rsp_ready/rsp_id/rsp_prdct   registered product response
//   busy              either pipeline stage occupied

// 6x6 unsigned multiplier: six partial-product rows reduced by carry-save
// rows (6 -> 4 -> 3 -> 2) and one final carry-propagate add.
module multplr (
    input  logic [5:0]  x,
    input  logic [5:0]  y,
    output logic [11:0] p
);
    logic [11:0] pp [6];
    logic [11:0] s1, c1, s2, c2, s3, c3, s4, c4;

    genvar i;
    generate
        for (i = 0; i < 6; i++) begin : g_pp
            assign pp[i] = {6'b0, x & {6{y[i]}}} << i;
        end
    endgenerate

    // The product fits in 12 bits, so carries past bit 11 are always zero
    // in the final sum and can be dropped at every level.
    assign s1 = pp[0] ^ pp[1] ^ pp[2];
    assign c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign s2 = pp[3] ^ pp[4] ^ pp[5];
    assign c2 = ((pp[3] & pp[4]) | (pp[3] & pp[5]) | (pp[4] & pp[5])) << 1;

    assign s3 = s1 ^ c1 ^ s2;
    assign c3 = ((s1 & c1) | (s1 & s2) | (c1 & s2)) << 1;

    assign s4 = s3 ^ c3 ^ c2;
    assign c4 = ((s3 & c3) | (s3 & c2) | (c3 & c2)) << 1;

    assign p = s4 + c4;
endmodule

module mult_share_arb #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [6*N_REQ-1:0] x_in,
    input  logic [6*N_REQ-1:0] y_in,
    output logic [N_REQ-1:0]   ack,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [11:0]        rsp_prdct,
    input  logic               rsp_ready,
    output logic               busy
);
    logic           s1_v;
    logic [IDW-1:0] s1_id;
    logic [5:0]     s1_x, s1_y;
    logic [IDW-1:0] last;

    logic [5:0]     xs [N_REQ];
    logic [5:0]     ys [N_REQ];
    logic [11:0]    prod;
    logic           stall;
    logic           found;
    logic           grant;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    int             idx;

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_slice
            assign xs[g] = x_in[6*g +: 6];
            assign ys[g] = y_in[6*g +: 6];
        end
    endgenerate

    assign stall = rsp_valid & ~rsp_ready;
    assign busy  = s1_v | rsp_valid;

    // Search starts just after the last winner and wraps, so the most
    // recently served requester has the lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx  = (int'(last) + k) % N_REQ;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Reset gating keeps ack quiet while rst is held, even though the
    // pipeline itself is empty and would otherwise accept.
    assign grant = found & ~stall & ~rst;

    always_comb begin
        ack = '0;
        if (grant) ack[win] = 1'b1;
    end

    multplr u_mult (
        .x (s1_x),
        .y (s1_y),
        .p (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s1_id     <= '0;
            s1_x      <= '0;
            s1_y      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prdct <= '0;
            last      <= IDW'(N_REQ - 1);
        end else if (!stall) begin
            rsp_valid <= s1_v;
            rsp_id    <= s1_id;
            rsp_prdct <= prod;
            if (grant) begin
                s1_v  <= 1'b1;
                s1_id <= win;
                s1_x  <= xs[win];
                s1_y  <= ys[win];
                last  <= win;
            end else begin
                s1_v  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_share_arb.sv
// Purpose : self-checking bench for mult_share_arb with a transaction-level reference.
// Latency : reference tracks grant -> capture -> response occupancy per clock.
// Backpr. : rsp_ready is randomized and also held low in a directed scenario.
module tb_mult_share_arb;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [6*N-1:0] x_in = '0;
    logic [6*N-1:0] y_in = '0;
    logic [N-1:0]  ack;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [11:0]   rsp_prdct;
    logic          rsp_ready = 1'b1;
    logic          busy;

    int checks = 0;
    int errors = 0;
    bit started = 0;
    logic [N-1:0] last_ack = '0;
    int resp_cnt = 0;
    int grant_cnt = 0;

    // Reference: a captured transaction and an output transaction, each
    // either absent or carrying (id, x*y); plus the round-robin pointer.
    bit m_s1v = 0;
    int m_s1id = 0;
    int m_s1p = 0;
    bit m_ov = 0;
    int m_oid = 0;
    int m_op = 0;
    int m_last = N - 1;

    mult_share_arb #(.N_REQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prdct (rsp_prdct),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] r, input int l);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (l + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int prod_of(input int w);
        return int'(x_in[6*w +: 6]) * int'(y_in[6*w +: 6]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1v <= 0; m_s1id <= 0; m_s1p <= 0;
            m_ov <= 0; m_oid <= 0; m_op <= 0;
            m_last <= N - 1;
        end else if (!(m_ov && !rsp_ready)) begin
            m_ov  <= m_s1v;
            m_oid <= m_s1id;
            m_op  <= m_s1p;
            if (winner(req, m_last) >= 0) begin
                m_s1v  <= 1;
                m_s1id <= winner(req, m_last);
                m_s1p  <= prod_of(winner(req, m_last));
                m_last <= winner(req, m_last);
            end else begin
                m_s1v <= 0;
            end
        end
    end

    logic [N-1:0] exp_ack;
    int w_cmp;
    always @(negedge clk) begin
        if (started) begin
            w_cmp = winner(req, m_last);
            exp_ack = '0;
            if (!rst && !(m_ov && !rsp_ready) && w_cmp >= 0) exp_ack[w_cmp] = 1'b1;
            chk("ack", 32'(ack), 32'(exp_ack));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_ov));
            chk("busy", 32'(busy), 32'(m_s1v | m_ov));
            if (m_ov) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_oid));
                chk("rsp_prdct", 32'(rsp_prdct), 32'(m_op));
            end
            last_ack = ack;
            if (ack != '0) grant_cnt++;
            if (rsp_valid && rsp_ready) resp_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        started = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requesters in mask renew (new operands) only after their ack or when idle.
    task automatic stream_step(input logic [N-1:0] mask);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (last_ack[i] || !req[i])) begin
                req[i] = 1'b1;
                x_in[6*i +: 6] = 6'($urandom);
                y_in[6*i +: 6] = 6'($urandom);
            end
        end
    endtask

    task automatic rand_step();
        @(posedge clk);
        #1;
        rsp_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < N; i++) begin
            if (!req[i] || last_ack[i]) begin
                req[i] = ($urandom_range(0, 2) != 0);
                x_in[6*i +: 6] = 6'($urandom);
                y_in[6*i +: 6] = 6'($urandom);
            end else if ($urandom_range(0, 19) == 0) begin
                req[i] = 1'b0;
            end
        end
    endtask

    logic [1:0]  hold_id;
    logic [11:0] hold_p;
    int r0, g0;
    logic [N-1:0] exp_rr [5];
    int rr_id [5];
    int rr_p [5];
    logic [N-1:0] exp_wrap [3];

    initial begin
        // Reset state and single operation
        do_reset();
        @(negedge clk);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_id", 32'(rsp_id), 32'd0);
        chk("reset_prdct", 32'(rsp_prdct), 32'd0);
        tick();
        req = 4'b0001; x_in[5:0] = 6'd5; y_in[5:0] = 6'd7;
        @(negedge clk);
        chk("single_ack", 32'(ack), 32'd1);
        tick(); req = '0;
        @(negedge clk);
        chk("single_s1_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd0);
        chk("single_prdct", 32'(rsp_prdct), 32'd35);
        @(negedge clk);
        chk("single_busy_after", 32'(busy), 32'd0);

        // Max operands on requester 2
        tick();
        req = 4'b0100; x_in[17:12] = 6'd63; y_in[17:12] = 6'd63;
        @(negedge clk);
        chk("max_ack", 32'(ack), 32'd4);
        tick(); req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("max_prdct", 32'(rsp_prdct), 32'd3969);
        chk("max_id", 32'(rsp_id), 32'd2);

        // Full sweep through requester 1, one grant per cycle
        tick();
        r0 = resp_cnt; g0 = grant_cnt;
        for (int p = 0; p < 4096; p++) begin
            req = 4'b0010;
            x_in[11:6] = 6'(p >> 6);
            y_in[11:6] = 6'(p);
            tick();
        end
        req = '0;
        repeat (4) tick();
        chk("sweep_grants", 32'(grant_cnt - g0), 32'd4096);
        chk("sweep_responses", 32'(resp_cnt - r0), 32'd4096);

        // Round robin with all requesting
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            x_in[6*i +: 6] = 6'(i + 1);
            y_in[6*i +: 6] = 6'(i + 2);
        end
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
        rr_id[0] = 0; rr_id[1] = 1; rr_id[2] = 2; rr_id[3] = 3; rr_id[4] = 0;
        rr_p[0] = 2; rr_p[1] = 6; rr_p[2] = 12; rr_p[3] = 20; rr_p[4] = 2;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 5) chk("rr_ack", 32'(ack), 32'(exp_rr[k]));
            if (k >= 2) begin
                chk("rr_valid", 32'(rsp_valid), 32'd1);
                chk("rr_id", 32'(rsp_id), 32'(rr_id[k-2]));
                chk("rr_prdct", 32'(rsp_prdct), 32'(rr_p[k-2]));
            end
            tick();
            if (k == 4) req = '0;
        end

        // Wrap / priority from the reset pointer
        do_reset();
        req = 4'b1010;
        exp_wrap[0] = 4'b0010; exp_wrap[1] = 4'b1000; exp_wrap[2] = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wrap_ack", 32'(ack), 32'(exp_wrap[k]));
            tick();
        end
        req = '0;
        repeat (3) tick();

        // Backpressure on a two-requester stream
        do_reset();
        r0 = resp_cnt; g0 = grant_cnt;
        repeat (4) stream_step(4'b1001);
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                hold_id = rsp_id; hold_p = rsp_prdct;
                chk("bp_valid", 32'(rsp_valid), 32'd1);
            end
            chk("bp_ack", 32'(ack), 32'd0);
            chk("bp_hold_id", 32'(rsp_id), 32'(hold_id));
            chk("bp_hold_prdct", 32'(rsp_prdct), 32'(hold_p));
            stream_step(4'b1001);
        end
        rsp_ready = 1'b1;
        repeat (10) stream_step(4'b1001);
        req = '0;
        repeat (4) tick();
        chk("bp_no_loss", 32'(resp_cnt - r0), 32'(grant_cnt - g0));

        // Randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) rand_step();
        req = '0; rsp_ready = 1'b1;
        repeat (4) tick();

        // Asynchronous reset with both stages full
        do_reset();
        repeat (3) stream_step(4'b0001);
        @(negedge clk);
        chk("mid_full_valid", 32'(rsp_valid), 32'd1);
        chk("mid_full_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        req = '0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_prdct", 32'(rsp_prdct), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        req = 4'b0100; x_in[17:12] = 6'd9; y_in[17:12] = 6'd10;
        @(negedge clk);
        chk("post_rst_ack", 32'(ack), 32'd4);
        tick(); req = '0;
        @(negedge clk);
        chk("post_rst_no_stale", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("post_rst_valid", 32'(rsp_valid), 32'd1);
        chk("post_rst_prdct", 32'(rsp_prdct), 32'd90);
        chk("post_rst_id", 32'(rsp_id), 32'd2);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
